// File: rtl/bitrev_reorder.sv
// Output reorder buffer for the SDF FFT tail: accepts frames in bit-reversed order and
// emits them in natural order, ping-ponging between two N-entry banks.
module bitrev_reorder #(
    parameter int N_LOG2 = 4,
    parameter int DW     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] x_in_re,
    input  logic signed [DW-1:0] x_in_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] x_out_re,
    output logic signed [DW-1:0] x_out_im,
    output logic                 out_first,
    output logic                 out_last
);

    localparam int N  = 1 << N_LOG2;
    localparam int AW = N_LOG2;

    logic          r_wr_bank;
    logic          r_rd_bank;
    logic [AW-1:0] r_wr_cnt;
    logic [AW-1:0] r_rd_cnt;
    logic [1:0]    r_full;
    logic [2*DW-1:0] r_mem [0:2*N-1];

    logic          w_accept;
    logic          w_fetch;
    logic          w_wr_done;
    logic          w_rd_done;
    logic [AW-1:0] w_wr_addr;
    logic [1:0]    w_full_nxt;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    assign in_ready  = !r_full[r_wr_bank];
    assign w_accept  = in_valid & in_ready;
    assign w_fetch   = r_full[r_rd_bank] & (!out_valid | out_ready);
    assign w_wr_done = w_accept & (r_wr_cnt == AW'(N - 1));
    assign w_rd_done = w_fetch & (r_rd_cnt == AW'(N - 1));
    assign w_wr_addr = bitrev(r_wr_cnt);

    // A set and a clear in the same cycle always hit different banks, so both apply.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_done) w_full_nxt[r_wr_bank] = 1'b1;
        if (w_rd_done) w_full_nxt[r_rd_bank] = 1'b0;
    end

    // NOTE: the sample RAM has no reset so it maps onto block memory; the full flags
    // guarantee no stale word is ever read after reset.
    always_ff @(posedge clk) begin
        if (w_accept) r_mem[{r_wr_bank, w_wr_addr}] <= {x_in_re, x_in_im};
    end

    // NOTE: all sequential state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_full    <= '0;
        end else begin
            r_full <= w_full_nxt;
            if (w_accept) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
                if (w_wr_done) r_wr_bank <= ~r_wr_bank;
            end
            if (w_fetch) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
                if (w_rd_done) r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    // Output register holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            x_out_re  <= '0;
            x_out_im  <= '0;
        end else if (w_fetch) begin
            {x_out_re, x_out_im} <= r_mem[{r_rd_bank, r_rd_cnt}];
            out_valid <= 1'b1;
            out_first <= (r_rd_cnt == '0);
            out_last  <= (r_rd_cnt == AW'(N - 1));
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bitrev_reorder.sv
// Directed bench for bitrev_reorder: hand tables plus a bit-reversal scoreboard, with
// stall, back-pressure, reset and hold-stability scenarios.
module tb_bitrev_reorder;

    localparam int N_LOG2 = 4;
    localparam int DW     = 16;
    localparam int N      = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] x_in_re = '0;
    logic signed [DW-1:0] x_in_im = '0;
    logic                 in_ready;
    logic                 out_valid;
    logic signed [DW-1:0] x_out_re;
    logic signed [DW-1:0] x_out_im;
    logic                 out_first;
    logic                 out_last;

    bitrev_reorder #(.N_LOG2(N_LOG2), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_in_re(x_in_re), .x_in_im(x_in_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_out_re(x_out_re), .x_out_im(x_out_im),
        .out_first(out_first), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bench model state
    logic [31:0] in_q [$];
    logic [33:0] exp_q [$];
    logic [31:0] frm [N];
    logic [15:0] out_log [$];
    logic [33:0] held;
    bit          hold_pending = 0;
    bit          prev_ov = 0;
    int          frm_cnt = 0;
    int          cyc = 0;
    int          n_acc, n_out, n_stall;
    int          last_acc_cyc, rise_cyc, first_cons, last_cons;

    logic [15:0] t2_exp [16] = '{16'd0, 16'd8, 16'd4, 16'd12, 16'd2, 16'd10, 16'd6, 16'd14,
                                 16'd1, 16'd9, 16'd5, 16'd13, 16'd3, 16'd11, 16'd7, 16'd15};

    function automatic int brev(input int j);
        int r = 0;
        for (int b = 0; b < N_LOG2; b++) if (j[b]) r |= (1 << (N_LOG2 - 1 - b));
        return r;
    endfunction

    task automatic clear_stats();
        n_acc = 0; n_out = 0; n_stall = 0;
        last_acc_cyc = -1; rise_cyc = -1; first_cons = -1; last_cons = -1;
        out_log.delete();
    endtask

    // One clock: drive at posedge+1, observe at negedge, return at next posedge+1.
    task automatic tick(input bit iv_en, input bit ordy);
        logic [33:0] cur;
        in_valid  = iv_en && (in_q.size() > 0);
        {x_in_re, x_in_im} = in_valid ? in_q[0] : 32'd0;
        out_ready = ordy;
        @(negedge clk);
        cur = {out_first, out_last, x_out_re, x_out_im};
        if (hold_pending) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'(cur), 64'(held));
        end
        if (out_valid && !prev_ov && rise_cyc < 0) rise_cyc = cyc;
        prev_ov = out_valid;
        if (in_valid && !in_ready) n_stall++;
        if (in_valid && in_ready) begin
            frm[frm_cnt] = in_q.pop_front();
            frm_cnt++; n_acc++; last_acc_cyc = cyc;
            if (frm_cnt == N) begin
                for (int j = 0; j < N; j++)
                    exp_q.push_back({1'(j == 0), 1'(j == N - 1), frm[brev(j)]});
                frm_cnt = 0;
            end
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("out_extra", 64'(out_valid), 64'd0);
            else check("out_data", 64'(cur), 64'(exp_q.pop_front()));
            if (first_cons < 0) first_cons = cyc;
            last_cons = cyc;
            out_log.push_back(x_out_re);
            n_out++;
        end
        hold_pending = out_valid && !out_ready;
        held = cur;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int want, input bit rnd, input int budget);
        int guard = 0;
        while (n_out < want && guard < budget) begin
            tick(rnd ? 1'($urandom_range(0, 1)) : 1'b1, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            guard++;
        end
        if (n_out < want) check("run_timeout", 64'(n_out), 64'(want));
    endtask

    task automatic do_reset(input string tag);
        in_valid = 0; out_ready = 0;
        rst_n = 0;
        #2;
        check({tag, "_ov"}, 64'(out_valid), 64'd0);
        check({tag, "_ir"}, 64'(in_ready), 64'd1);
        check({tag, "_re"}, 64'(x_out_re), 64'd0);
        check({tag, "_im"}, 64'(x_out_im), 64'd0);
        check({tag, "_fl"}, 64'({out_first, out_last}), 64'd0);
        in_q.delete(); exp_q.delete();
        frm_cnt = 0; hold_pending = 0; prev_ov = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        check({tag, "_ir_post"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] re, im;
        #1;
        // Reset, then reset again with one full bank and a partial frame pending.
        clear_stats();
        do_reset("rst0");
        for (int k = 0; k < 21; k++) in_q.push_back({16'(k + 500), 16'(k)});
        repeat (21) tick(1, 0);
        do_reset("rst_mid");

        // Single frame, hand-computed order and latency.
        clear_stats();
        for (int k = 0; k < N; k++) in_q.push_back({16'(k), 16'(100 + k)});
        run(16, 0, 200);
        for (int j = 0; j < N; j++) check($sformatf("t2_re%0d", j), 64'(out_log[j]), 64'(t2_exp[j]));
        check("t2_latency", 64'(rise_cyc - last_acc_cyc), 64'd2);

        // Four back-to-back frames at full rate.
        clear_stats();
        for (int k = 0; k < 4 * N; k++) in_q.push_back({16'(1000 + k), 16'(-k)});
        run(64, 0, 300);
        check("t3_in_stall", 64'(n_stall), 64'd0);
        check("t3_continuous", 64'(last_cons - first_cons), 64'd63);

        // Output blocked: two frames fit, the third stalls, then all drain.
        clear_stats();
        for (int k = 0; k < 3 * N; k++) in_q.push_back({16'(2000 + k), 16'(3000 - k)});
        repeat (60) tick(1, 0);
        check("t4_accepts", 64'(n_acc), 64'd32);
        check("t4_in_ready", 64'(in_ready), 64'd0);
        check("t4_no_out", 64'(n_out), 64'd0);
        run(48, 0, 400);
        check("t4_all_in", 64'(n_acc), 64'd48);

        // Random handshakes over 100 frames with extreme values.
        clear_stats();
        for (int f = 0; f < 100; f++) begin
            for (int k = 0; k < N; k++) begin
                re = 16'($urandom); im = 16'($urandom);
                if (k == 3) re = 16'h8000;
                if (k == 5) re = 16'h7fff;
                if (k == 7) im = 16'h8000;
                if (k == 11) im = 16'h7fff;
                in_q.push_back({re, im});
            end
        end
        run(1600, 1, 20000);
        check("t5_drained", 64'(exp_q.size()), 64'd0);

        // Hold a presented sample for 5 stalled cycles, then consume it once.
        clear_stats();
        for (int k = 0; k < N; k++) in_q.push_back({16'(k), 16'(200 + k)});
        repeat (16) tick(1, 0);
        for (int g = 0; g < 10 && !prev_ov; g++) tick(0, 0);
        check("t6_valid", 64'(prev_ov), 64'd1);
        repeat (5) tick(0, 0);
        check("t6_held_count", 64'(n_out), 64'd0);
        tick(0, 1);
        check("t6_consumed", 64'(n_out), 64'd1);
        out_ready = 0;
        @(negedge clk);
        check("t6_next_valid", 64'(out_valid), 64'd1);
        check("t6_next_re", 64'(x_out_re), 64'd8);
        @(posedge clk);
        #1;
        cyc++;
        run(16, 0, 100);
        check("final_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
